ctrl_pipeline: RTL and testbench

- Consumer end of the instruction decoder's control bundle.
- Accepts decoded control in ID and carries it through the ID/EX, EX/MEM and MEM/WB stage registers, delivering each field to the stage that uses it.
- Detects load-use hazards and generates stall.
- Resolves beq/bne in MEM and generates pcsrc plus flush of wrong-path instructions.
- Sits between the decoder, the datapath stage registers and the PC/IF logic.

---
 rtl/ctrl_pipeline_if.sv | 46 ++++
 rtl/ctrl_pipeline.sv | 116 +++++++++++
 tb/tb_ctrl_pipeline.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipeline_if.sv
// Control-bundle interface between the decoder/datapath side and ctrl_pipeline.
interface ctrl_pipeline_if #(
    parameter int unsigned REGW = 5
);
    logic [1:0]      id_branch;
    logic [1:0]      id_aluop;
    logic            id_memread;
    logic            id_memwrite;
    logic            id_memtoreg;
    logic            id_regdst;
    logic            id_regwrite;
    logic            id_alusrc;
    logic [REGW-1:0] id_rs;
    logic [REGW-1:0] id_rt;
    logic [REGW-1:0] id_rd;
    logic            ex_zero;

    logic [1:0]      ex_aluop;
    logic            ex_alusrc;
    logic [REGW-1:0] ex_wreg;
    logic            mem_memread;
    logic            mem_memwrite;
    logic [REGW-1:0] mem_wreg;
    logic            wb_memtoreg;
    logic            wb_regwrite;
    logic [REGW-1:0] wb_wreg;
    logic            stall;
    logic            pcsrc;
    logic            flush_ifid;

    // Decoder / datapath side
    modport master (
        output id_branch, id_aluop, id_memread, id_memwrite, id_memtoreg,
               id_regdst, id_regwrite, id_alusrc, id_rs, id_rt, id_rd, ex_zero,
        input  ex_aluop, ex_alusrc, ex_wreg, mem_memread, mem_memwrite, mem_wreg,
               wb_memtoreg, wb_regwrite, wb_wreg, stall, pcsrc, flush_ifid
    );

    // Control pipeline side
    modport slave (
        input  id_branch, id_aluop, id_memread, id_memwrite, id_memtoreg,
               id_regdst, id_regwrite, id_alusrc, id_rs, id_rt, id_rd, ex_zero,
        output ex_aluop, ex_alusrc, ex_wreg, mem_memread, mem_memwrite, mem_wreg,
               wb_memtoreg, wb_regwrite, wb_wreg, stall, pcsrc, flush_ifid
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// Control pipeline: carries decoded control through ID/EX, EX/MEM, MEM/WB,
// generates load-use stall and branch redirect/flush.
module ctrl_pipeline #(
    parameter int unsigned REGW = 5
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);

    typedef struct packed {
        logic [1:0]      branch;
        logic [1:0]      aluop;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regdst;
        logic            regwrite;
        logic            alusrc;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic [1:0]      branch;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic [REGW-1:0] wreg;
        logic            zero;
    } exmem_t;

    typedef struct packed {
        logic            memtoreg;
        logic            regwrite;
        logic [REGW-1:0] wreg;
    } memwb_t;

    idex_t           idex_q,  idex_d;
    exmem_t          exmem_q, exmem_d;
    memwb_t          memwb_q, memwb_d;
    logic [REGW-1:0] ex_wreg_c;
    logic            hazard_c;
    logic            stall_c;
    logic            pcsrc_c;

    // Hazard detection, branch resolution and next stage-register contents
    always_comb begin
        idex_d  = '0;
        exmem_d = '0;
        memwb_d = '0;

        ex_wreg_c = idex_q.regdst ? idex_q.rd : idex_q.rt;
        pcsrc_c   = (exmem_q.branch[0] & exmem_q.zero) |
                    (exmem_q.branch[1] & ~exmem_q.zero);
        hazard_c  = idex_q.memread & (idex_q.rt != '0) &
                    ((idex_q.rt == bus.id_rs) | (idex_q.rt == bus.id_rt));
        // A redirect squashes the stalled instruction, so the stall is moot
        stall_c   = hazard_c & ~pcsrc_c;

        if (!(stall_c || pcsrc_c)) begin
            idex_d.branch   = bus.id_branch;
            idex_d.aluop    = bus.id_aluop;
            idex_d.memread  = bus.id_memread;
            idex_d.memwrite = bus.id_memwrite;
            idex_d.memtoreg = bus.id_memtoreg;
            idex_d.regdst   = bus.id_regdst;
            idex_d.regwrite = bus.id_regwrite;
            idex_d.alusrc   = bus.id_alusrc;
            idex_d.rt       = bus.id_rt;
            idex_d.rd       = bus.id_rd;
        end

        if (!pcsrc_c) begin
            exmem_d.branch   = idex_q.branch;
            exmem_d.memread  = idex_q.memread;
            exmem_d.memwrite = idex_q.memwrite;
            exmem_d.memtoreg = idex_q.memtoreg;
            exmem_d.regwrite = idex_q.regwrite;
            exmem_d.wreg     = ex_wreg_c;
            exmem_d.zero     = bus.ex_zero;
        end

        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.wreg     = exmem_q.wreg;
    end

    // Stage registers; reset loads bubbles everywhere
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ex_aluop     = idex_q.aluop;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_wreg      = ex_wreg_c;
    assign bus.mem_memread  = exmem_q.memread;
    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.mem_wreg     = exmem_q.wreg;
    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.wb_wreg      = memwb_q.wreg;
    assign bus.stall        = stall_c;
    assign bus.pcsrc        = pcsrc_c;
    assign bus.flush_ifid   = pcsrc_c;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed instruction stream, instruction-level
// reference model compared every cycle, plus literal spot checks.
module tb_ctrl_pipeline;

    typedef struct packed {
        logic [1:0] branch;
        logic [1:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrc;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    localparam instr_t NOP = '0;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ctrl_pipeline_if #(.REGW(5)) bus ();

    ctrl_pipeline #(.REGW(5)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- instruction constructors ----------------
    function automatic instr_t mk_lw(input logic [4:0] rs, input logic [4:0] rt);
        instr_t i = NOP;
        i.memread = 1; i.memtoreg = 1; i.alusrc = 1; i.regwrite = 1;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t mk_sw(input logic [4:0] rs, input logic [4:0] rt);
        instr_t i = NOP;
        i.memwrite = 1; i.alusrc = 1; i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t mk_add(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd);
        instr_t i = NOP;
        i.aluop = 2'b10; i.regdst = 1; i.regwrite = 1;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t mk_br(input logic [1:0] kind);
        instr_t i = NOP;
        i.branch = kind; i.aluop = 2'b01; i.rs = 5'd1; i.rt = 5'd2;
        return i;
    endfunction

    // ---------------- reference model ----------------
    instr_t m_ex = NOP, m_mem = NOP, m_wb = NOP;
    logic   m_mem_zero = 1'b0;
    logic   armed = 1'b0;

    function automatic logic [4:0] dest(input instr_t i);
        return i.regdst ? i.rd : i.rt;
    endfunction

    function automatic instr_t cur_id();
        instr_t i;
        i.branch = bus.id_branch;   i.aluop = bus.id_aluop;
        i.memread = bus.id_memread; i.memwrite = bus.id_memwrite;
        i.memtoreg = bus.id_memtoreg; i.regdst = bus.id_regdst;
        i.regwrite = bus.id_regwrite; i.alusrc = bus.id_alusrc;
        i.rs = bus.id_rs; i.rt = bus.id_rt; i.rd = bus.id_rd;
        return i;
    endfunction

    // Branch in MEM: beq takes on zero, bne on nonzero, illegal 11 always takes
    function automatic logic m_taken();
        case (m_mem.branch)
            2'b01:   return m_mem_zero;
            2'b10:   return !m_mem_zero;
            2'b11:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic m_stall();
        if (m_taken()) return 1'b0;
        return m_ex.memread && (m_ex.rt != 0) &&
               ((m_ex.rt == bus.id_rs) || (m_ex.rt == bus.id_rt));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ex = NOP; m_mem = NOP; m_wb = NOP; m_mem_zero = 1'b0;
            armed = 1'b1;
        end else begin
            automatic logic tk = m_taken();
            automatic logic st = m_stall();
            m_wb       = m_mem;
            m_mem      = tk ? NOP : m_ex;
            m_mem_zero = tk ? 1'b0 : bus.ex_zero;
            m_ex       = (tk || st) ? NOP : cur_id();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("m_ex_aluop",     32'(bus.ex_aluop),     32'(m_ex.aluop));
            chk("m_ex_alusrc",    32'(bus.ex_alusrc),    32'(m_ex.alusrc));
            chk("m_ex_wreg",      32'(bus.ex_wreg),      32'(dest(m_ex)));
            chk("m_mem_memread",  32'(bus.mem_memread),  32'(m_mem.memread));
            chk("m_mem_memwrite", 32'(bus.mem_memwrite), 32'(m_mem.memwrite));
            chk("m_mem_wreg",     32'(bus.mem_wreg),     32'(dest(m_mem)));
            chk("m_wb_memtoreg",  32'(bus.wb_memtoreg),  32'(m_wb.memtoreg));
            chk("m_wb_regwrite",  32'(bus.wb_regwrite),  32'(m_wb.regwrite));
            chk("m_wb_wreg",      32'(bus.wb_wreg),      32'(dest(m_wb)));
            chk("m_stall",        32'(bus.stall),        32'(m_stall()));
            chk("m_pcsrc",        32'(bus.pcsrc),        32'(m_taken()));
            chk("m_flush",        32'(bus.flush_ifid),   32'(m_taken()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input instr_t i, input logic z, input logic r);
        bus.id_branch = i.branch;     bus.id_aluop = i.aluop;
        bus.id_memread = i.memread;   bus.id_memwrite = i.memwrite;
        bus.id_memtoreg = i.memtoreg; bus.id_regdst = i.regdst;
        bus.id_regwrite = i.regwrite; bus.id_alusrc = i.alusrc;
        bus.id_rs = i.rs; bus.id_rt = i.rt; bus.id_rd = i.rd;
        bus.ex_zero = z;
        rst = r;
    endtask

    // Present one ID bundle for a cycle; returns at the following negedge
    task automatic step(input instr_t i, input logic z, input logic r);
        @(posedge clk);
        #1;
        drive(i, z, r);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(NOP, 1'b0, 1'b0);
    endtask

    initial begin
        drive(NOP, 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b1);
        step(NOP, 1'b0, 1'b0);
        // reset state
        chk("rst_ex_aluop",     32'(bus.ex_aluop), 0);
        chk("rst_ex_wreg",      32'(bus.ex_wreg), 0);
        chk("rst_mem_memwrite", 32'(bus.mem_memwrite), 0);
        chk("rst_wb_regwrite",  32'(bus.wb_regwrite), 0);
        chk("rst_stall",        32'(bus.stall), 0);
        chk("rst_pcsrc",        32'(bus.pcsrc), 0);

        // lw latency through the stages
        step(mk_lw(5'd1, 5'd8), 1'b0, 1'b0);
        step(NOP, 1'b0, 1'b0);
        chk("lw_ex_alusrc", 32'(bus.ex_alusrc), 1);
        chk("lw_ex_wreg",   32'(bus.ex_wreg), 8);
        step(NOP, 1'b0, 1'b0);
        chk("lw_mem_memread", 32'(bus.mem_memread), 1);
        chk("lw_mem_wreg",    32'(bus.mem_wreg), 8);
        step(NOP, 1'b0, 1'b0);
        chk("lw_wb_memtoreg", 32'(bus.wb_memtoreg), 1);
        chk("lw_wb_regwrite", 32'(bus.wb_regwrite), 1);
        chk("lw_wb_wreg",     32'(bus.wb_wreg), 8);
        idle(2);

        // load-use: one stall cycle, add held in ID
        step(mk_lw(5'd1, 5'd8), 1'b0, 1'b0);
        step(mk_add(5'd8, 5'd9, 5'd10), 1'b0, 1'b0);
        chk("lu_stall_on", 32'(bus.stall), 1);
        step(mk_add(5'd8, 5'd9, 5'd10), 1'b0, 1'b0);
        chk("lu_stall_off",  32'(bus.stall), 0);
        chk("lu_bubble_op",  32'(bus.ex_aluop), 0);
        chk("lu_bubble_wr",  32'(bus.ex_wreg), 0);
        step(NOP, 1'b0, 1'b0);
        chk("lu_add_aluop", 32'(bus.ex_aluop), 2);
        chk("lu_add_wreg",  32'(bus.ex_wreg), 10);
        idle(3);

        // lw to r0 never stalls
        step(mk_lw(5'd1, 5'd0), 1'b0, 1'b0);
        step(mk_add(5'd0, 5'd0, 5'd3), 1'b0, 1'b0);
        chk("r0_no_stall", 32'(bus.stall), 0);
        idle(3);

        // beq taken: redirect two cycles after issue, wrong path squashed
        step(mk_br(2'b01), 1'b0, 1'b0);
        step(mk_sw(5'd1, 5'd2), 1'b1, 1'b0);
        step(mk_add(5'd1, 5'd2, 5'd5), 1'b0, 1'b0);
        chk("beq_t_pcsrc", 32'(bus.pcsrc), 1);
        chk("beq_t_flush", 32'(bus.flush_ifid), 1);
        for (int k = 0; k < 3; k++) begin
            step(NOP, 1'b0, 1'b0);
            chk("beq_t_no_memwrite", 32'(bus.mem_memwrite), 0);
            chk("beq_t_no_regwrite", 32'(bus.wb_regwrite), 0);
        end
        idle(1);

        // beq not taken: wrong-path instructions complete normally
        step(mk_br(2'b01), 1'b0, 1'b0);
        step(mk_sw(5'd1, 5'd2), 1'b0, 1'b0);
        step(mk_add(5'd1, 5'd2, 5'd5), 1'b0, 1'b0);
        chk("beq_n_pcsrc", 32'(bus.pcsrc), 0);
        chk("beq_n_flush", 32'(bus.flush_ifid), 0);
        step(NOP, 1'b0, 1'b0);
        chk("beq_n_memwrite", 32'(bus.mem_memwrite), 1);
        step(NOP, 1'b0, 1'b0);
        step(NOP, 1'b0, 1'b0);
        chk("beq_n_regwrite", 32'(bus.wb_regwrite), 1);
        chk("beq_n_wreg",     32'(bus.wb_wreg), 5);
        idle(2);

        // bne taken coincides with a load-use condition: redirect wins
        step(mk_br(2'b10), 1'b0, 1'b0);
        step(mk_lw(5'd1, 5'd7), 1'b0, 1'b0);
        step(mk_add(5'd7, 5'd1, 5'd4), 1'b0, 1'b0);
        chk("bne_pcsrc", 32'(bus.pcsrc), 1);
        chk("bne_stall", 32'(bus.stall), 0);
        step(NOP, 1'b0, 1'b0);
        chk("bne_ex_bubble",  32'(bus.ex_alusrc), 0);
        chk("bne_ex_wreg",    32'(bus.ex_wreg), 0);
        chk("bne_mem_bubble", 32'(bus.mem_memread), 0);
        chk("bne_mem_wreg",   32'(bus.mem_wreg), 0);
        chk("bne_pcsrc_off",  32'(bus.pcsrc), 0);
        idle(3);

        // back-to-back taken beqs: younger one is squashed
        step(mk_br(2'b01), 1'b1, 1'b0);
        step(mk_br(2'b01), 1'b1, 1'b0);
        step(NOP, 1'b1, 1'b0);
        chk("bb_first_pcsrc", 32'(bus.pcsrc), 1);
        step(NOP, 1'b1, 1'b0);
        chk("bb_second_pcsrc", 32'(bus.pcsrc), 0);
        idle(2);

        // illegal branch=11 always redirects
        step(mk_br(2'b11), 1'b0, 1'b0);
        step(NOP, 1'b0, 1'b0);
        step(NOP, 1'b0, 1'b0);
        chk("ill_pcsrc", 32'(bus.pcsrc), 1);
        idle(3);

        // mid-stream reset with sw in MEM and a pending load-use
        step(mk_add(5'd1, 5'd2, 5'd6), 1'b0, 1'b0);
        step(mk_sw(5'd1, 5'd2), 1'b0, 1'b0);
        step(mk_lw(5'd1, 5'd3), 1'b0, 1'b0);
        step(mk_add(5'd3, 5'd0, 5'd2), 1'b0, 1'b1);
        chk("mr_pre_memwrite", 32'(bus.mem_memwrite), 1);
        chk("mr_pre_regwrite", 32'(bus.wb_regwrite), 1);
        chk("mr_pre_stall",    32'(bus.stall), 1);
        step(mk_add(5'd3, 5'd0, 5'd2), 1'b0, 1'b0);
        chk("mr_memwrite", 32'(bus.mem_memwrite), 0);
        chk("mr_regwrite", 32'(bus.wb_regwrite), 0);
        chk("mr_stall",    32'(bus.stall), 0);
        chk("mr_pcsrc",    32'(bus.pcsrc), 0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
